alu_sched: RTL and testbench
============================

# alu_sched

Sequencer and two-port arbiter for the 8-bit processor ALU. It accepts operation requests from two requesters (e.g. instruction-execute path and address/loop unit), picks one round-robin, and drives the ALU operand and control inputs. It generates the ALU strobe edge on `alu_control[0]`, captures the ALU result, and returns it with a one-cycle acknowledge. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

## Interface
- `WIDTH`, 8, operand/result width; must match the ALU (8).
- `clk` in 1: single system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `req0`, `req1` in 1: request from requester 0 / 1; held until its ack.
- `op0`, `op1` in 2: operation code: 00 OR, 01 ADD, 10 MUL, 11 SUB.
- `a0`, `b0`, `a1`, `b1` in WIDTH: operands per requester; stable while req high.
- `ack0`, `ack1` out 1: one-cycle completion pulse; `result` valid in that cycle.
- `result` out WIDTH: last captured ALU output; held until next capture.
- `zero` out 1: `result == 0`, registered with result.
- `busy` out 1: high in every state except IDLE.
- `gnt_id` out 1: requester currently or last served.
- `alu_a1`, `alu_a2` out WIDTH: ALU operand inputs (registered).
- `alu_control` out 3: bit0 strobe (ALU acts on its rising edge); bit1 = op[0]; bit2 = op[1].
- `alu_o` in WIDTH: ALU output.

## Operation
- FSM states: IDLE, SETUP, FIRE, DONE.
- IDLE: if any req is high at the clock edge, latch the winner's operands into `alu_a1`/`alu_a2`, its op into `alu_control[2:1]`, and set `gnt_id`. Keep `alu_control[0]`=0 and go to SETUP.
- SETUP: set `alu_control[0]`<=1 and go to FIRE. The operands have been stable for one full cycle before the strobe edge.
- FIRE: capture `result`<=`alu_o`, `zero`<=(`alu_o`==0), and pulse the selected ack<=1. Set `alu_control[0]`<=0 and go to DONE.
- DONE: drop the ack, ignore all reqs, and go to IDLE.
- Arbitration:
  - If only one req is high, that requester wins.
  - If both are high, the winner is the requester not equal to `gnt_id`.
  - After reset `gnt_id`=1, so requester 0 wins the first tie.
- A req still high in IDLE after its ack counts as a new request. The requester must drop req in the ack cycle to avoid a repeat.
- Operands and op are sampled only in IDLE. Changes after the grant have no effect on the running operation.
- Arithmetic is the ALU's own; results are WIDTH bits.
  - ADD and SUB wrap modulo 2^WIDTH.
  - MUL keeps the low WIDTH bits.
  - OR is bitwise.
- The ALU status output is not driven by the ALU and is not connected.
- Reset values: state IDLE, `alu_control`=000, `alu_a1`=`alu_a2`=0, `result`=0, `zero`=1, `ack0`=`ack1`=0, `busy`=0, `gnt_id`=1.
- Reset mid-operation, in any state: return to IDLE with the reset values and do not acknowledge the aborted request. A strobe already issued is not retracted from the ALU, but its output is never captured.

## Timing
- Let edge E be the edge where IDLE samples a req high:
  - E+1: strobe rises.
  - E+2: result captured and ack high during the following cycle.
  - E+3: back in IDLE.
- Latency from req sampled to ack is 2 clocks. Throughput is one operation per 4 clocks.
- Back-to-back: the next grant can occur at edge E+4, when IDLE samples again.
- `alu_control[0]` is high for exactly one clock per operation. It is low for at least 2 clocks between strobes.
- `ack0` and `ack1` are never high in the same cycle. An ack is never high outside the cycle after FIRE.
- `busy` goes high the cycle after the grant edge and low in the cycle after DONE.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> all outputs take their reset values immediately (`zero`=1, `gnt_id`=1, `alu_control`=000).
- Single ADD: req0, op0=01, a0=0x12, b0=0x34 -> `alu_control` = 011 strobe, then `result`=0x46, `zero`=0, `ack0` pulse 2 clocks after the grant edge, `ack1` never high.
- Wrap and truncate:
  - req1 SUB 0x10-0x20 -> 0xF0.
  - req1 MUL 0x10*0x11 -> 0x10.
  - req0 OR 0x00|0x00 -> 0x00 with `zero`=1.
- Tie after reset: req0 and req1 both held -> served in order 0,1,0,1, each ack exactly 4 clocks apart, results match each requester's operands.
- Operand change after grant: change a0 in SETUP -> result uses the value sampled in IDLE.
- Reset during FIRE: no ack; after release, a fresh req0 ADD 1+1 completes normally with `result`=0x02.

Source files
------------

// File: rtl/alu_sched.sv
// Two-port round-robin sequencer for the 8-bit ALU: latches the winning request,
// issues one strobe pulse, captures the ALU output and returns a one-cycle ack.
module alu_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             gnt_id,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_o
);

  typedef enum logic [1:0] {IDLE, SETUP, FIRE, DONE} state_t;

  state_t state;
  logic   pick;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~gnt_id;
  end

  // NOTE: every register below uses non-blocking assignments so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alu_control <= 3'b000;
      alu_a1      <= '0;
      alu_a2      <= '0;
      result      <= '0;
      zero        <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      gnt_id      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt_id      <= pick;
            alu_a1      <= pick ? a1 : a0;
            alu_a2      <= pick ? b1 : b0;
            alu_control <= {(pick ? op1 : op0), 1'b0};
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          // Operands have now been stable for a full cycle; raise the strobe.
          alu_control[0] <= 1'b1;
          state          <= FIRE;
        end
        FIRE: begin
          result         <= alu_o;
          zero           <= (alu_o == '0);
          ack0           <= ~gnt_id;
          ack1           <= gnt_id;
          alu_control[0] <= 1'b0;
          state          <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed cases with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_alu_sched;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [1:0]       op0, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             ack0, ack1, zero, busy, gnt_id;
  logic [WIDTH-1:0] result, alu_a1, alu_a2;
  logic [WIDTH-1:0] alu_o = '0;
  logic [2:0]       alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .zero(zero),
    .busy(busy), .gnt_id(gnt_id),
    .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_control(alu_control),
    .alu_o(alu_o)
  );

  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a + b;
      2'b10:   return a * b;
      default: return a - b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The ALU itself: acts on the rising edge of its strobe.
  always @(posedge alu_control[0]) alu_o = alu_fn(alu_control[2:1], alu_a1, alu_a2);

  // Reference model: one transaction in flight, timed in edges since its grant.
  logic       m_active;
  int         m_k;
  logic       m_gnt;
  logic [1:0] m_op;
  logic [7:0] m_a, m_b, m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 1'b0; m_k = 0; m_gnt = 1'b1;
      m_op = 2'b00; m_a = 8'h00; m_b = 8'h00; m_res = 8'h00;
    end else if (m_active) begin
      m_k++;
      if (m_k == 2) m_res = alu_fn(m_op, m_a, m_b);
      if (m_k == 3) m_active = 1'b0;
    end else if (req0 || req1) begin
      if (req0 && !req1)      m_gnt = 1'b0;
      else if (req1 && !req0) m_gnt = 1'b1;
      else                    m_gnt = (m_gnt == 1'b0);
      if (m_gnt) begin m_op = op1; m_a = a1; m_b = b1; end
      else       begin m_op = op0; m_a = a0; m_b = b0; end
      m_active = 1'b1;
      m_k = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check("busy", busy, m_active);
      check("ack0", ack0, m_active && m_k == 2 && !m_gnt);
      check("ack1", ack1, m_active && m_k == 2 && m_gnt);
      check("alu_control", alu_control, {m_op, m_active && m_k == 1});
      check("alu_a1", alu_a1, m_a);
      check("alu_a2", alu_a2, m_b);
      check("result", result, m_res);
      check("zero", zero, m_res == 8'h00);
      check("gnt_id", gnt_id, m_gnt);
      check("ack_exclusive", ack0 & ack1, 1'b0);
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " zero"}, zero, 1'b1);
    check({tag, " gnt_id"}, gnt_id, 1'b1);
    check({tag, " alu_control"}, alu_control, 3'b000);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " result"}, result, 8'h00);
    check({tag, " acks"}, {ack0, ack1}, 2'b00);
    check({tag, " operands"}, {alu_a1, alu_a2}, 16'h0000);
  endtask

  task automatic run_op(input bit id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input bit mutate,
                        input string name);
    int n;
    bit seen;
    @(negedge clk);
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      if (mutate && n == 1) begin a0 = ~a0; b0 = b0 + 8'd1; op0 = ~op0; end
      if (n == 2) check({name, " strobe"}, alu_control, {op, 1'b1});
      if ((id && ack1) || (!id && ack0)) seen = 1'b1;
    end
    check({name, " ack_seen"}, seen, 1'b1);
    check({name, " latency"}, n, 3);
    check({name, " other_ack"}, id ? ack0 : ack1, 1'b0);
    check({name, " result"}, result, exp);
    check({name, " zero"}, zero, exp == 8'h00);
    if (id) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          ack_cyc[4];
    bit          ack_id[4];
    logic [7:0]  ack_res[4];
    int          n_ack;

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;

    run_op(1'b0, 2'b01, 8'h12, 8'h34, 8'h46, 1'b0, "add");
    run_op(1'b1, 2'b11, 8'h10, 8'h20, 8'hF0, 1'b0, "sub_wrap");
    run_op(1'b1, 2'b10, 8'h10, 8'h11, 8'h10, 1'b0, "mul_trunc");
    run_op(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, "or_zero");
    run_op(1'b0, 2'b01, 8'h20, 8'h05, 8'h25, 1'b1, "hold_operands");

    // Abort an operation in FIRE with an asynchronous mid-cycle reset.
    @(negedge clk);
    req0 = 1'b1; op0 = 2'b01; a0 = 8'h05; b0 = 8'h06;
    @(negedge clk);
    @(negedge clk);
    check("abort strobe_up", alu_control[0], 1'b1);
    #1 reset = 1'b1;
    #1 check_reset_values("async");
    req0 = 1'b0;
    @(negedge clk);
    check("abort no_ack", ack0, 1'b0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort idle_ack", ack0, 1'b0);
    end
    run_op(1'b0, 2'b01, 8'h01, 8'h01, 8'h02, 1'b0, "post_reset_add");

    // Tie after reset: both held, expect service order 0,1,0,1 at a 4-clock pitch.
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    req0 = 1'b1; op0 = 2'b01; a0 = 8'h03; b0 = 8'h04;
    req1 = 1'b1; op1 = 2'b10; a1 = 8'h05; b1 = 8'h06;
    n_ack = 0;
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ack_cyc[n_ack] = c;
        ack_id[n_ack]  = ack1;
        ack_res[n_ack] = result;
        n_ack++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie ack_count", n_ack, 4);
    if (n_ack == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("tie order", ack_id[i], i % 2);
        check("tie result", ack_res[i], (i % 2) ? 8'h1E : 8'h07);
        if (i > 0) check("tie spacing", ack_cyc[i] - ack_cyc[i-1], 4);
      end
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
      end
      r = $urandom;
      if (req0) begin
        if (ack0 && r[1:0] != 2'b00) req0 = 1'b0;
      end else if (r[3:2] == 2'b00) begin
        req0 = 1'b1; op0 = r[5:4]; a0 = r[15:8]; b0 = r[23:16];
      end
      r = $urandom;
      if (req1) begin
        if (ack1 && r[1:0] != 2'b00) req1 = 1'b0;
      end else if (r[3:2] == 2'b00) begin
        req1 = 1'b1; op1 = r[5:4]; a1 = r[15:8]; b1 = r[23:16];
      end
    end
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
